dmem_loader: RTL and testbench

DMEM_LOADER -- requirements
Module: dmem_loader

---
 rtl/dmem_loader_if.sv | 35 +++
 rtl/dmem_loader.sv | 128 ++++++++++++
 tb/tb_dmem_loader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_loader_if.sv
// Bus bundle for dmem_loader: CPU memory port, program-load byte stream and MMIO port.
// The slave modport is the loader side; master is the CPU/host side.
interface dmem_loader_if;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_data_out;
   logic       cpu_R;
   logic       cpu_W;
   logic       cpu_stop;
   logic [7:0] mem_in;
   logic       cpu_rst;

   logic       ld_valid;
   logic [7:0] ld_data;
   logic       ld_last;
   logic       ld_ready;
   logic       ld_start;
   logic [7:0] ld_count;
   logic       halted;

   logic [7:0] io_in;
   logic [7:0] io_out;
   logic       io_strobe;

   modport master (
      output cpu_addr, cpu_data_out, cpu_R, cpu_W, cpu_stop,
      output ld_valid, ld_data, ld_last, ld_start, io_in,
      input  mem_in, cpu_rst, ld_ready, ld_count, halted, io_out, io_strobe
   );

   modport slave (
      input  cpu_addr, cpu_data_out, cpu_R, cpu_W, cpu_stop,
      input  ld_valid, ld_data, ld_last, ld_start, io_in,
      output mem_in, cpu_rst, ld_ready, ld_count, halted, io_out, io_strobe
   );
endinterface

// File: rtl/dmem_loader.sv
// 256x8 data memory that is first filled from a byte stream, then serves a CPU until halt/reload.
// Optional memory-mapped I/O byte at IO_ADDR is enabled by defining DMEM_MMIO_EN.
module dmem_loader #(
   parameter logic [7:0] IO_ADDR = 8'hFF
) (
   input logic         clk,
   input logic         rst,
   dmem_loader_if.slave bus
);

   typedef enum logic [1:0] {LOAD, RUN, HALT} state_t;

   state_t     state;
   state_t     state_next;
   logic [7:0] ram [256];
   logic [7:0] ptr;
   logic [7:0] ptr_next;
   logic [7:0] count;
   logic [7:0] count_next;
   logic [7:0] io_reg;
   logic [7:0] io_next;
   logic       strobe_reg;
   logic       strobe_next;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       io_hit;

`ifdef DMEM_MMIO_EN
   assign io_hit = (bus.cpu_addr == IO_ADDR);
`else
   logic unused_cfg;
   assign io_hit     = 1'b0;
   assign unused_cfg = ^IO_ADDR;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= LOAD;
         ptr        <= 8'd0;
         count      <= 8'd0;
         io_reg     <= 8'd0;
         strobe_reg <= 1'b0;
      end else begin
         state      <= state_next;
         ptr        <= ptr_next;
         count      <= count_next;
         io_reg     <= io_next;
         strobe_reg <= strobe_next;
      end
   end

   // Reset blocks the write port so a reset landing mid-load leaves no stray byte.
   always_ff @(posedge clk) begin
      if (wr_en && rst) begin
         ram[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      state_next  = state;
      ptr_next    = ptr;
      count_next  = count;
      io_next     = io_reg;
      strobe_next = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = ptr;
      wr_data     = bus.ld_data;
      case (state)
         LOAD: begin
            if (bus.ld_valid) begin
               wr_en    = 1'b1;
               ptr_next = ptr + 8'd1;
               // Count wraps so a full 256-byte image reports zero.
               if (bus.ld_last || (ptr == 8'hFF)) begin
                  count_next = ptr + 8'd1;
                  ptr_next   = 8'd0;
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            if (!bus.cpu_W) begin
               if (io_hit) begin
                  io_next     = bus.cpu_data_out;
                  strobe_next = 1'b1;
               end else begin
                  wr_en   = 1'b1;
                  wr_addr = bus.cpu_addr;
                  wr_data = bus.cpu_data_out;
               end
            end
            if (bus.ld_start) begin
               state_next = LOAD;
               ptr_next   = 8'd0;
            end else if (bus.cpu_stop) begin
               state_next = HALT;
            end
         end
         HALT: begin
            if (bus.ld_start) begin
               state_next = LOAD;
               ptr_next   = 8'd0;
            end
         end
         default: begin
            state_next = LOAD;
            ptr_next   = 8'd0;
         end
      endcase
   end

   // Read is combinational, so a same-cycle read/write returns the old byte.
   always_comb begin
      bus.mem_in = 8'd0;
      if ((state == RUN) && !bus.cpu_R) begin
         bus.mem_in = io_hit ? bus.io_in : ram[bus.cpu_addr];
      end
   end

   assign bus.ld_ready  = (state == LOAD);
   assign bus.cpu_rst   = (state == LOAD);
   assign bus.halted    = (state == HALT);
   assign bus.ld_count  = count;
   assign bus.io_out    = io_reg;
   assign bus.io_strobe = strobe_reg;

endmodule

// File: tb/tb_dmem_loader.sv
// Randomized scoreboard bench for dmem_loader; a behavioural memory model predicts every cycle.
// Build with DMEM_MMIO_EN defined to exercise the memory-mapped I/O byte.
module tb_dmem_loader;

   typedef struct {
      logic [7:0] mem_in;
      bit         chk_mem;
      logic [7:0] cpu_rst;
      logic [7:0] ld_ready;
      logic [7:0] halted;
      logic [7:0] ld_count;
      logic [7:0] io_out;
      logic [7:0] io_strobe;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_loader_if bus();

   dmem_loader #(.IO_ADDR(8'hFF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   logic       s_rst, s_R, s_W, s_stop, s_valid, s_last, s_start;
   logic [7:0] s_addr, s_data, s_ldata, s_io;

   bit         m_valid = 1'b0;
   bit         m_loading, m_stopped, m_strobe, m_mmio;
   int         m_ptr;
   logic [7:0] m_count, m_io;
   logic [7:0] m_ram [256];
   bit         m_known [256];

   task automatic checkField(string name, logic [7:0] act, logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(exp_t e);
      checkField("cpu_rst",   {7'd0, bus.cpu_rst},   e.cpu_rst);
      checkField("ld_ready",  {7'd0, bus.ld_ready},  e.ld_ready);
      checkField("halted",    {7'd0, bus.halted},    e.halted);
      checkField("ld_count",  bus.ld_count,          e.ld_count);
      checkField("io_out",    bus.io_out,            e.io_out);
      checkField("io_strobe", {7'd0, bus.io_strobe}, e.io_strobe);
      if (e.chk_mem) checkField("mem_in", bus.mem_in, e.mem_in);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checkOutput(e);
      end
   end

   task automatic setIdle();
      s_rst = 1'b1; s_R = 1'b1; s_W = 1'b1; s_stop = 1'b0; s_start = 1'b0;
      s_valid = 1'b0; s_last = 1'b0; s_addr = 8'd0; s_data = 8'd0; s_ldata = 8'd0;
      s_io = 8'($urandom);
   endtask

   // One clock of stimulus: predict this cycle's outputs, then advance the model past the edge.
   task automatic applyStimulus();
      exp_t e;
      bit   running, nstrobe;
      @(posedge clk);
      #1;
      rst = s_rst;
      bus.cpu_addr = s_addr; bus.cpu_data_out = s_data; bus.cpu_R = s_R; bus.cpu_W = s_W;
      bus.cpu_stop = s_stop; bus.ld_valid = s_valid; bus.ld_data = s_ldata;
      bus.ld_last = s_last; bus.ld_start = s_start; bus.io_in = s_io;
      if (m_valid) begin
         running     = !m_loading && !m_stopped;
         e.cpu_rst   = {7'd0, m_loading};
         e.ld_ready  = {7'd0, m_loading};
         e.halted    = {7'd0, !m_loading && m_stopped};
         e.ld_count  = m_count;
         e.io_out    = m_io;
         e.io_strobe = {7'd0, m_strobe};
         e.mem_in    = 8'd0;
         e.chk_mem   = !(!m_loading && m_stopped);
         if (running && !s_R) begin
            if (m_mmio && s_addr == 8'hFF) e.mem_in = s_io;
            else begin
               e.mem_in  = m_ram[s_addr];
               e.chk_mem = m_known[s_addr];
            end
         end
         sb.push_back(e);
      end
      if (!s_rst) begin
         m_valid = 1'b1; m_loading = 1'b1; m_stopped = 1'b0; m_ptr = 0;
         m_count = 8'd0; m_io = 8'd0; m_strobe = 1'b0;
      end else if (m_valid) begin
         nstrobe = 1'b0;
         if (m_loading) begin
            if (s_valid) begin
               m_ram[m_ptr] = s_ldata;
               m_known[m_ptr] = 1'b1;
               m_ptr++;
               if (s_last || m_ptr == 256) begin
                  m_count = 8'(m_ptr % 256);
                  m_ptr = 0;
                  m_loading = 1'b0;
                  m_stopped = 1'b0;
               end
            end
         end else if (!m_stopped) begin
            if (!s_W) begin
               if (m_mmio && s_addr == 8'hFF) begin
                  m_io = s_data;
                  nstrobe = 1'b1;
               end else begin
                  m_ram[s_addr] = s_data;
                  m_known[s_addr] = 1'b1;
               end
            end
            if (s_start) begin
               m_loading = 1'b1; m_ptr = 0;
            end else if (s_stop) m_stopped = 1'b1;
         end else if (s_start) begin
            m_loading = 1'b1; m_stopped = 1'b0; m_ptr = 0;
         end
         m_strobe = nstrobe;
      end
   endtask

   task automatic loadByte(logic [7:0] d, logic last);
      setIdle(); s_valid = 1'b1; s_ldata = d; s_last = last;
      applyStimulus();
   endtask

   task automatic cpuOp(logic [7:0] a, logic r, logic w, logic [7:0] d);
      setIdle(); s_addr = a; s_R = r; s_W = w; s_data = d;
      applyStimulus();
   endtask

   task automatic startLoad();
      setIdle(); s_start = 1'b1;
      applyStimulus();
   endtask

   initial begin
`ifdef DMEM_MMIO_EN
      m_mmio = 1'b1;
`else
      m_mmio = 1'b0;
`endif
      for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
      setIdle(); s_rst = 1'b0;
      applyStimulus();
      s_rst = 1'b0;
      applyStimulus();
      setIdle();
      applyStimulus();

      loadByte(8'hC0, 1'b0);
      loadByte(8'h05, 1'b0);
      loadByte(8'hCC, 1'b1);
      cpuOp(8'h00, 1'b0, 1'b1, 8'h00);
      cpuOp(8'h02, 1'b0, 1'b1, 8'h00);

      cpuOp(8'h40, 1'b1, 1'b0, 8'h5A);
      cpuOp(8'h40, 1'b0, 1'b1, 8'h00);
      cpuOp(8'h40, 1'b0, 1'b0, 8'h11);
      cpuOp(8'h40, 1'b0, 1'b1, 8'h00);

      setIdle(); s_valid = 1'b1; s_ldata = 8'hEE;
      applyStimulus();
      cpuOp(8'h03, 1'b0, 1'b1, 8'h00);

      for (int i = 0; i < 40; i++)
         cpuOp(8'($urandom_range(0, 254)), 1'($urandom), 1'($urandom), 8'($urandom));

      cpuOp(8'h10, 1'b1, 1'b0, 8'h77);
      setIdle(); s_stop = 1'b1;
      applyStimulus();
      cpuOp(8'h10, 1'b1, 1'b0, 8'h99);
      cpuOp(8'h10, 1'b1, 1'b1, 8'h00);
      startLoad();
      loadByte(8'hA1, 1'b0);
      loadByte(8'hA2, 1'b0);
      loadByte(8'hA3, 1'b1);
      cpuOp(8'h10, 1'b0, 1'b1, 8'h00);
      cpuOp(8'h01, 1'b0, 1'b1, 8'h00);

      setIdle(); s_start = 1'b1; s_stop = 1'b1;
      applyStimulus();
      for (int i = 0; i < 256; i++) loadByte(8'($urandom), 1'b0);
      cpuOp(8'h00, 1'b0, 1'b1, 8'h00);
      cpuOp(8'hFE, 1'b0, 1'b1, 8'h00);
      cpuOp(8'h80, 1'b0, 1'b1, 8'h00);

      startLoad();
      loadByte(8'h31, 1'b0);
      loadByte(8'h32, 1'b0);
      setIdle(); s_rst = 1'b0;
      applyStimulus();
      loadByte(8'hD0, 1'b0);
      loadByte(8'hD1, 1'b0);
      loadByte(8'hD2, 1'b1);
      for (int a = 0; a < 3; a++) cpuOp(8'(a), 1'b0, 1'b1, 8'h00);

      cpuOp(8'hFF, 1'b1, 1'b0, 8'h42);
      cpuOp(8'h00, 1'b1, 1'b1, 8'h00);
      cpuOp(8'h00, 1'b1, 1'b1, 8'h00);
      setIdle(); s_addr = 8'hFF; s_R = 1'b0; s_io = 8'h7E;
      applyStimulus();

      for (int i = 0; i < 300; i++) begin
         setIdle();
         s_rst   = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         s_addr  = 8'($urandom);
         s_data  = 8'($urandom);
         s_R     = 1'($urandom);
         s_W     = 1'($urandom);
         s_stop  = ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0;
         s_start = ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0;
         s_valid = 1'($urandom);
         s_ldata = 8'($urandom);
         s_last  = ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0;
         applyStimulus();
      end

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
